// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the five-stage pipeline stall/flush controller:
// FSM state encodings and the default register-file address width.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 3;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a debug
// readout never under-reports a long-running condition.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: resolves memory wait, taken redirects,
// load-use hazards and HALT by priority and drives the pipeline enables.
module pipe_hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int REG_ADDR_W       = pipe_ctrl_pkg::REG_ADDR_W,
    parameter int CNT_W            = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_is_halt,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_br_taken,
    input  logic                  mem_busy,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  pipe_freeze,
    output logic                  halted,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    import pipe_ctrl_pkg::*;

    // The first bubble is issued from RUN, so the counter covers only the rest.
    localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [1:0] bub_q;
    logic [1:0] bub_d;
    logic       load_use;
    logic       flush_evt;

    assign load_use = id_valid & ex_valid & ex_is_load &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        flush_evt    = 1'b0;
        state_d      = state_q;
        bub_d        = bub_q;

        case (state_q)
            // MEM_WAIT falls back into normal hazard evaluation once memory is ready.
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    pipe_freeze = 1'b1;
                    state_d     = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                    if (ex_br_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush_evt    = 1'b1;
                    end else if (load_use) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_d = ST_LU_STALL;
                            bub_d   = BUB_INIT;
                        end
                    end else if (id_valid && id_is_halt) begin
                        pc_we    = 1'b0;
                        if_id_we = 1'b0;
                        state_d  = ST_HALT;
                    end
                end
            end
            ST_LU_STALL: begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
                if (mem_busy) begin
                    pipe_freeze = 1'b1;
                end else if (bub_q <= 2'd1) begin
                    state_d = ST_RUN;
                    bub_d   = 2'd0;
                end else begin
                    bub_d = bub_q - 2'd1;
                end
            end
            default: begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            bub_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    assign halted = (state_q == ST_HALT);
    assign state  = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (~pc_we),
        .count_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush_evt),
        .count_o (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (1 and 3 load-use bubbles, the
// second with narrow counters so saturation is reachable) against a rule model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       idValid;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       useRs1;
        logic       useRs2;
        logic       isHalt;
        logic       exValid;
        logic       exLoad;
        logic [2:0] exRd;
        logic       brTaken;
        logic       memBusy;
    } stim_t;

    typedef struct {
        int remaining;
        bit halted;
        bit memWait;
        int stalls;
        int flushes;
    } model_t;

    typedef struct {
        bit       pcWe;
        bit       ifIdWe;
        bit       flush;
        bit       bubble;
        bit       freeze;
        bit       halted;
        bit [1:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       idValid, useRs1, useRs2, isHalt, exValid, exLoad, brTaken, memBusy;
    logic [2:0] rs1, rs2, exRd;

    logic        pcWeA, ifIdWeA, ifIdFlushA, idExBubbleA, pipeFreezeA, haltedA;
    logic        pcWeB, ifIdWeB, ifIdFlushB, idExBubbleB, pipeFreezeB, haltedB;
    logic [1:0]  stateA, stateB;
    logic [15:0] stallA, flushA;
    logic [7:0]  stallB, flushB;

    int     vecCount  = 0;
    int     missCount = 0;
    model_t mdl[2];
    model_t nxt[2];
    exp_t   expd[2];
    int     bubbles[2] = '{1, 3};
    int     cntMax[2]  = '{65535, 255};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .REG_ADDR_W(3), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .id_valid(idValid), .id_rs1(rs1), .id_rs2(rs2),
        .id_use_rs1(useRs1), .id_use_rs2(useRs2), .id_is_halt(isHalt),
        .ex_valid(exValid), .ex_is_load(exLoad), .ex_rd(exRd),
        .ex_br_taken(brTaken), .mem_busy(memBusy),
        .pc_we(pcWeA), .if_id_we(ifIdWeA), .if_id_flush(ifIdFlushA),
        .id_ex_bubble(idExBubbleA), .pipe_freeze(pipeFreezeA), .halted(haltedA),
        .state(stateA), .stall_cnt(stallA), .flush_cnt(flushA)
    );

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .REG_ADDR_W(3), .CNT_W(8)) dutB (
        .clk(clk), .rst(rst), .id_valid(idValid), .id_rs1(rs1), .id_rs2(rs2),
        .id_use_rs1(useRs1), .id_use_rs2(useRs2), .id_is_halt(isHalt),
        .ex_valid(exValid), .ex_is_load(exLoad), .ex_rd(exRd),
        .ex_br_taken(brTaken), .mem_busy(memBusy),
        .pc_we(pcWeB), .if_id_we(ifIdWeB), .if_id_flush(ifIdFlushB),
        .id_ex_bubble(idExBubbleB), .pipe_freeze(pipeFreezeB), .halted(haltedB),
        .state(stateB), .stall_cnt(stallB), .flush_cnt(flushB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        rst     = s.rst;
        idValid = s.idValid;
        rs1     = s.rs1;
        rs2     = s.rs2;
        useRs1  = s.useRs1;
        useRs2  = s.useRs2;
        isHalt  = s.isHalt;
        exValid = s.exValid;
        exLoad  = s.exLoad;
        exRd    = s.exRd;
        brTaken = s.brTaken;
        memBusy = s.memBusy;
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rst     = ($urandom_range(0, 99) < 2);
        s.idValid = ($urandom_range(0, 99) < 80);
        s.rs1     = 3'($urandom_range(0, 3));
        s.rs2     = 3'($urandom_range(0, 3));
        s.useRs1  = 1'($urandom_range(0, 1));
        s.useRs2  = 1'($urandom_range(0, 1));
        s.isHalt  = ($urandom_range(0, 99) < 4);
        s.exValid = ($urandom_range(0, 99) < 80);
        s.exLoad  = ($urandom_range(0, 99) < 50);
        s.exRd    = 3'($urandom_range(0, 3));
        s.brTaken = ($urandom_range(0, 99) < 15);
        s.memBusy = ($urandom_range(0, 99) < 15);
        return s;
    endfunction

    // Rule model: remaining = extra stall cycles still owed after the first bubble.
    function automatic void modelStep(input model_t m, input int bub, input int cmax,
                                      output exp_t e, output model_t n);
        bit loadUse;
        loadUse = idValid && exValid && exLoad &&
                  ((useRs1 && rs1 == exRd) || (useRs2 && rs2 == exRd));
        n = m;
        e = '{pcWe: 1, ifIdWe: 1, flush: 0, bubble: 0, freeze: 0, halted: 0, st: 2'd0};
        e.st = m.halted ? 2'd3 : (m.remaining > 0) ? 2'd1 : m.memWait ? 2'd2 : 2'd0;
        if (m.halted) begin
            e.pcWe = 0; e.ifIdWe = 0; e.bubble = 1; e.halted = 1;
        end else if (m.remaining > 0) begin
            e.pcWe = 0; e.ifIdWe = 0; e.bubble = 1;
            if (memBusy) e.freeze = 1;
            else n.remaining = m.remaining - 1;
        end else if (memBusy) begin
            e.pcWe = 0; e.ifIdWe = 0; e.freeze = 1;
            n.memWait = 1;
        end else begin
            n.memWait = 0;
            if (brTaken) begin
                e.flush = 1; e.bubble = 1;
                if (m.flushes < cmax) n.flushes = m.flushes + 1;
            end else if (loadUse) begin
                e.pcWe = 0; e.ifIdWe = 0; e.bubble = 1;
                n.remaining = bub - 1;
            end else if (idValid && isHalt) begin
                e.pcWe = 0; e.ifIdWe = 0;
                n.halted = 1;
            end
        end
        if (!e.pcWe && m.stalls < cmax) n.stalls = m.stalls + 1;
        if (rst) n = '{0, 0, 0, 0, 0};
    endfunction

    task automatic compareOutputs(input int d);
        string p;
        p = (d == 0) ? "A." : "B.";
        checkOutput({p, "pc_we"},        32'(d == 0 ? pcWeA       : pcWeB),       32'(expd[d].pcWe));
        checkOutput({p, "if_id_we"},     32'(d == 0 ? ifIdWeA     : ifIdWeB),     32'(expd[d].ifIdWe));
        checkOutput({p, "if_id_flush"},  32'(d == 0 ? ifIdFlushA  : ifIdFlushB),  32'(expd[d].flush));
        checkOutput({p, "id_ex_bubble"}, 32'(d == 0 ? idExBubbleA : idExBubbleB), 32'(expd[d].bubble));
        checkOutput({p, "pipe_freeze"},  32'(d == 0 ? pipeFreezeA : pipeFreezeB), 32'(expd[d].freeze));
        checkOutput({p, "halted"},       32'(d == 0 ? haltedA     : haltedB),     32'(expd[d].halted));
        checkOutput({p, "state"},        32'(d == 0 ? stateA      : stateB),      32'(expd[d].st));
    endtask

    task automatic compareCounters(input int d);
        string p;
        p = (d == 0) ? "A." : "B.";
        checkOutput({p, "stall_cnt"}, (d == 0) ? 32'(stallA) : 32'(stallB), 32'(mdl[d].stalls));
        checkOutput({p, "flush_cnt"}, (d == 0) ? 32'(flushA) : 32'(flushB), 32'(mdl[d].flushes));
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic stepCycle();
        #4;
        for (int d = 0; d < 2; d++) begin
            modelStep(mdl[d], bubbles[d], cntMax[d], expd[d], nxt[d]);
            compareOutputs(d);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            mdl[d] = nxt[d];
            compareCounters(d);
        end
    endtask

    task automatic runStim(input stim_t s, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(s);
            stepCycle();
        end
    endtask

    initial begin
        stim_t s;
        stim_t lu;

        s = idleStim();
        s.rst = 1'b1;
        applyStimulus(s);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) mdl[d] = '{0, 0, 0, 0, 0};

        runStim(idleStim(), 10);

        lu = idleStim();
        lu.idValid = 1; lu.exValid = 1; lu.exLoad = 1; lu.exRd = 3'd3;
        lu.rs1 = 3'd3; lu.useRs1 = 1;
        runStim(lu, 1);
        runStim(idleStim(), 5);

        s = idleStim(); s.rst = 1;
        runStim(s, 1);
        s = lu; s.brTaken = 1;
        runStim(s, 1);
        runStim(idleStim(), 2);

        s = idleStim(); s.rst = 1;
        runStim(s, 1);
        runStim(lu, 1);
        s = idleStim(); s.memBusy = 1;
        runStim(s, 4);
        runStim(idleStim(), 5);

        s = idleStim(); s.rst = 1;
        runStim(s, 1);
        s = idleStim(); s.idValid = 1; s.isHalt = 1;
        runStim(s, 1);
        s = idleStim(); s.brTaken = 1;
        runStim(s, 3);
        s = idleStim(); s.rst = 1;
        runStim(s, 1);
        runStim(idleStim(), 2);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(randStim());
            stepCycle();
        end

        s = idleStim(); s.rst = 1;
        runStim(s, 1);
        s = idleStim(); s.brTaken = 1;
        runStim(s, 270);
        s = idleStim(); s.idValid = 1; s.isHalt = 1;
        runStim(s, 270);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
